// File: rtl/adc_scale_pkg.sv
// Shared widths, cycle counts, FSM encoding and the double-dabble step
// used by the ADC scaling/BCD sequencer.
package adc_scale_pkg;
    localparam int SAMPLE_W   = 12;
    localparam int DIGITS     = 6;
    localparam int PROD_W     = 31;
    localparam int QUO_W      = 20;
    localparam int BCD_W      = 24;
    localparam int DIV_CYCLES = 31;
    localparam int BCD_CYCLES = 20;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DIV  = 3'd2,
        ST_BCD  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    // Add 3 to every digit >= 5, then shift in the next binary bit.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                     input logic bin_msb);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            adj[4*d +: 4] = (adj[4*d +: 4] >= 4'd5) ? adj[4*d +: 4] + 4'd3 : adj[4*d +: 4];
        end
        return (adj << 1) | BCD_W'(bin_msb);
    endfunction
endpackage

// File: rtl/adc_scale_sequencer_bin2bcd_seq.sv
// Sequential double-dabble: the start cycle performs the first step, so the
// full 20-step conversion ends with o_done one cycle after the last step.
module bin2bcd_seq
    import adc_scale_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [QUO_W-1:0] i_bin,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);
    logic [QUO_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [4:0]       r_cnt;
    logic             r_active;
    logic             r_done;

    // Shift/add-3 loop; r_cnt counts the steps still to go after the start step.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= 5'd0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_bcd    <= dabble_step('0, i_bin[QUO_W-1]);
                r_bin    <= i_bin << 1;
                r_cnt    <= 5'(BCD_CYCLES - 1);
                r_active <= 1'b1;
            end else if (r_active) begin
                r_bcd <= dabble_step(r_bcd, r_bin[QUO_W-1]);
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_bcd  = r_bcd;
endmodule

// File: rtl/adc_scale_sequencer.sv
// Round-robin shared ADC scaler: grant, multiply by FULL_SCALE, restoring
// divide by ADC_MAX, convert to six BCD digits, present one result per job.
module adc_scale_sequencer
    import adc_scale_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int FULL_SCALE = 500000,
    parameter int ADC_MAX    = 4095,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_CH-1:0]          i_req,
    input  logic [NUM_CH*SAMPLE_W-1:0] i_sample,
    output logic [NUM_CH-1:0]          o_ack,
    output logic                       o_busy,
    output logic                       o_out_valid,
    output logic [CH_W-1:0]            o_out_ch,
    output logic [3:0]                 o_dig_5,
    output logic [3:0]                 o_dig_4,
    output logic [3:0]                 o_dig_3,
    output logic [3:0]                 o_dig_2,
    output logic [3:0]                 o_dig_1,
    output logic [3:0]                 o_dig_0
);
    localparam int REM_W = $clog2(ADC_MAX + 1);

    state_t              r_state;
    logic [CH_W-1:0]     r_ptr;
    logic [CH_W-1:0]     r_ch;
    logic [SAMPLE_W-1:0] r_sample;
    logic [PROD_W-1:0]   r_prod;
    logic [REM_W-1:0]    r_rem;
    logic [4:0]          r_cnt;
    logic                r_busy;
    logic                r_out_valid;
    logic [CH_W-1:0]     r_out_ch;
    logic [BCD_W-1:0]    r_dig;

    logic                w_any;
    logic [CH_W-1:0]     w_grant;
    logic                w_take;
    logic [CH_W-1:0]     w_ptr_nx;
    logic [REM_W:0]      w_rem_sh;
    logic                w_ge;
    logic [REM_W-1:0]    w_rem_nx;
    logic [PROD_W-1:0]   w_quo_nx;
    logic                w_bcd_start;
    logic                w_bcd_done;
    logic [BCD_W-1:0]    w_bcd;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_any && i_req[(int'(r_ptr) + k) % NUM_CH]) begin
                w_any   = 1'b1;
                w_grant = CH_W'((int'(r_ptr) + k) % NUM_CH);
            end else begin
                w_any   = w_any;
            end
        end
    end

    assign w_take   = (r_state == ST_IDLE) && w_any && !i_reset;
    assign w_ptr_nx = CH_W'((int'(w_grant) + 1) % NUM_CH);
    assign o_ack    = w_take ? (NUM_CH'(1) << w_grant) : '0;

    // One restoring-divide step; the quotient bit shifts into the product register.
    assign w_rem_sh = {r_rem, r_prod[PROD_W-1]};
    assign w_ge     = (w_rem_sh >= (REM_W+1)'(ADC_MAX));
    assign w_rem_nx = w_ge ? REM_W'(w_rem_sh - (REM_W+1)'(ADC_MAX)) : REM_W'(w_rem_sh);
    assign w_quo_nx = {r_prod[PROD_W-2:0], w_ge};

    // The converter starts on the final divide step so BCD spans exactly 20 cycles.
    assign w_bcd_start = (r_state == ST_DIV) && (r_cnt == 5'd0);

    bin2bcd_seq u_bin2bcd (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (w_bcd_start),
        .i_bin   (w_quo_nx[QUO_W-1:0]),
        .o_done  (w_bcd_done),
        .o_bcd   (w_bcd)
    );

    // Job sequencing FSM with registered status and result outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_ch        <= '0;
            r_sample    <= '0;
            r_prod      <= '0;
            r_rem       <= '0;
            r_cnt       <= 5'd0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_dig       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_sample <= i_sample[SAMPLE_W*int'(w_grant) +: SAMPLE_W];
                        r_ch     <= w_grant;
                        r_ptr    <= w_ptr_nx;
                        r_busy   <= 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_prod  <= PROD_W'(r_sample) * PROD_W'(FULL_SCALE);
                    r_rem   <= '0;
                    r_cnt   <= 5'(DIV_CYCLES - 1);
                    r_state <= ST_DIV;
                end
                ST_DIV: begin
                    r_rem  <= w_rem_nx;
                    r_prod <= w_quo_nx;
                    if (r_cnt == 5'd0) begin
                        r_state <= ST_BCD;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                ST_BCD: begin
                    if (w_bcd_done) begin
                        r_dig       <= w_bcd;
                        r_out_ch    <= r_ch;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_out_valid = r_out_valid;
    assign o_out_ch    = r_out_ch;
    assign o_dig_5     = r_dig[23:20];
    assign o_dig_4     = r_dig[19:16];
    assign o_dig_3     = r_dig[15:12];
    assign o_dig_2     = r_dig[11:8];
    assign o_dig_1     = r_dig[7:4];
    assign o_dig_0     = r_dig[3:0];
endmodule

// File: tb/tb_adc_scale_sequencer.sv
// Scoreboard bench: stimulus queues expected grants/results, monitors compare.
module tb_adc_scale_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [47:0] sample;
    logic [3:0]  ack;
    logic        busy;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [3:0]  d5, d4, d3, d2, d1, d0;

    adc_scale_sequencer #(.NUM_CH(4), .FULL_SCALE(500000), .ADC_MAX(4095)) dut (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_sample(sample),
        .o_ack(ack), .o_busy(busy), .o_out_valid(out_valid), .o_out_ch(out_ch),
        .o_dig_5(d5), .o_dig_4(d4), .o_dig_3(d3), .o_dig_2(d2), .o_dig_1(d1), .o_dig_0(d0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [1:0]  q_ack_exp[$];
    int          q_ack_cyc[$];
    logic [1:0]  q_res_ch[$];
    logic [23:0] q_res_val[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Grant monitor: channel order and no grant while busy.
    always @(negedge clk) begin
        if (!rst && ack != 4'd0) begin
            check("ack_while_busy", {31'd0, busy}, 32'd0);
            if (q_ack_exp.size() == 0) begin
                check("unexpected_ack", {28'd0, ack}, 32'd0);
            end else begin
                check("ack_channel", {28'd0, ack}, {28'd0, 4'd1 << q_ack_exp.pop_front()});
            end
            q_ack_cyc.push_back(cyc);
        end
    end

    // Result monitor: channel, digits and ack-to-result latency.
    always @(negedge clk) begin
        if (out_valid) begin
            if (q_res_val.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got ch=%0d digits=%h expected none", out_ch,
                         {d5, d4, d3, d2, d1, d0});
            end else begin
                check("out_ch", {30'd0, out_ch}, {30'd0, q_res_ch.pop_front()});
                check("digits", {8'd0, d5, d4, d3, d2, d1, d0}, {8'd0, q_res_val.pop_front()});
                if (q_ack_cyc.size() != 0) begin
                    check("latency", cyc - q_ack_cyc.pop_front(), 32'd53);
                end
            end
        end
    end

    task automatic wait_ack(input int ch, output int acyc);
        bit seen = 1'b0;
        acyc = -1;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (ack[ch]) begin
                seen = 1'b1;
                acyc = cyc;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack[%0d]", ch);
        end
    endtask

    task automatic wait_results();
        for (int t = 0; t < 400 && q_res_val.size() != 0; t++) @(negedge clk);
        check("results_drained", q_res_val.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_single(input int ch, input logic [11:0] val, input logic [23:0] exp);
        int a;
        @(posedge clk); #1;
        sample[12*ch +: 12] = val;
        q_ack_exp.push_back(2'(ch));
        q_res_ch.push_back(2'(ch));
        q_res_val.push_back(exp);
        req[ch] = 1'b1;
        wait_ack(ch, a);
        @(posedge clk); #1;
        req[ch] = 1'b0;
        wait_results();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int ab[5];
        int chs[5];
        rst = 1'b1;
        req = 4'd0;
        sample = 48'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack", {28'd0, ack}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_outs", {7'd0, out_valid, out_ch, d5, d4, d3, d2, d1, d0}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full-scale sample on ch0 with busy profile.
        @(posedge clk); #1;
        sample[11:0] = 12'd4095;
        q_ack_exp.push_back(2'd0);
        q_res_ch.push_back(2'd0);
        q_res_val.push_back(24'h500000);
        req[0] = 1'b1;
        wait_ack(0, a);
        @(posedge clk); #1;
        req[0] = 1'b0;
        for (int k = 1; k <= 53; k++) begin
            @(negedge clk);
            check("busy_in_job", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        check("busy_after_job", {31'd0, busy}, 32'd0);
        wait_results();

        run_single(2, 12'd2048, 24'h250061);
        run_single(1, 12'd1,    24'h000122);
        run_single(3, 12'd0,    24'h000000);

        // All four requesting; ch0 keeps requesting and is granted again after ch3.
        @(posedge clk); #1;
        sample = {12'd3000, 12'd2048, 12'd1, 12'd0};
        chs = '{0, 1, 2, 3, 0};
        q_res_val.push_back(24'h000000);
        q_res_val.push_back(24'h000122);
        q_res_val.push_back(24'h250061);
        q_res_val.push_back(24'h366300);
        q_res_val.push_back(24'h000000);
        for (int i = 0; i < 5; i++) begin
            q_ack_exp.push_back(2'(chs[i]));
            q_res_ch.push_back(2'(chs[i]));
        end
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(chs[i], ab[i]);
            @(posedge clk); #1;
            if (i != 0) req[chs[i]] = 1'b0;
        end
        for (int i = 1; i < 5; i++) check("ack_spacing", ab[i] - ab[i-1], 32'd54);
        wait_results();

        run_single(3, 12'd2048, 24'h250061);

        // Abort a ch2 job mid-divide; pointer would otherwise favour ch3.
        sample[35:24] = 12'd4095;
        q_ack_exp.push_back(2'd2);
        req[2] = 1'b1;
        wait_ack(2, a);
        @(posedge clk); #1;
        req[2] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_outs", {7'd0, out_valid, out_ch, d5, d4, d3, d2, d1, d0}, 32'd0);
        q_ack_cyc.delete();
        repeat (80) @(negedge clk);
        @(posedge clk); #1;
        sample[11:0] = 12'd0;
        sample[23:12] = 12'd1;
        sample[47:36] = 12'd3000;
        q_ack_exp.push_back(2'd1);
        q_ack_exp.push_back(2'd3);
        q_res_ch.push_back(2'd1);
        q_res_val.push_back(24'h000122);
        q_res_ch.push_back(2'd3);
        q_res_val.push_back(24'h366300);
        req = 4'b1010;
        wait_ack(1, a);
        @(posedge clk); #1;
        req[1] = 1'b0;
        wait_ack(3, a);
        @(posedge clk); #1;
        req[3] = 1'b0;
        wait_results();
        check("ack_queue_drained", q_ack_exp.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
